// File: rtl/instr_encoder_issue.sv
// rtl/instr_encoder_issue.sv - MIPS/FPU instruction encoder with issue FIFO; DOUBLE_FMT_EN enables ADD_D/SUB_D
module instr_encoder_issue #(
    parameter int                 DEPTH     = 4,
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    input  logic              clr_err,
    output logic [15:0]       word_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (op_sel)
            5'd0:  enc_word = {6'h00, rs, rt, rd, 5'h00, 6'h20};
            5'd1:  enc_word = {6'h00, rs, rt, rd, 5'h00, 6'h22};
            5'd2:  enc_word = {6'h00, rs, rt, rd, 5'h00, 6'h2a};
            5'd3:  enc_word = {6'h00, rs, 5'h00, 5'h00, 5'h00, 6'h08};
            5'd4:  enc_word = {6'h00, rs, rt, 5'h00, 5'h00, 6'h18};
            5'd5:  enc_word = {6'h00, 5'h00, 5'h00, rd, 5'h00, 6'h10};
            5'd6:  enc_word = {6'h00, 5'h00, 5'h00, rd, 5'h00, 6'h12};
            5'd7:  enc_word = {6'h23, rs, rt, imm};
            5'd8:  enc_word = {6'h2b, rs, rt, imm};
            5'd9:  enc_word = {6'h04, rs, rt, imm};
            5'd10: enc_word = {6'h05, rs, rt, imm};
            5'd11: enc_word = {6'h08, rs, rt, imm};
            5'd12: enc_word = {6'h0e, rs, rt, imm};
            5'd13: enc_word = {6'h02, target};
            5'd14: enc_word = {6'h03, target};
            // FPU fields go ft, fs, fd: rt lands before rs in the word
            5'd15: enc_word = {6'h11, 5'h10, rt, rs, rd, 6'h00};
            5'd16: enc_word = {6'h11, 5'h10, rt, rs, rd, 6'h01};
`ifdef DOUBLE_FMT_EN
            5'd17: enc_word = {6'h11, 5'h11, rt, rs, rd, 6'h00};
            5'd18: enc_word = {6'h11, 5'h11, rt, rs, rd, 6'h01};
`endif
            default: enc_legal = 1'b0;
        endcase
    end

    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign out_instr = out_valid ? mem[rd_ptr] : '0;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_addr   <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                out_addr   <= out_addr + ADDR_W'(4);
                word_count <= word_count + 16'd1;
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && pop) begin
                count <= count - (AW+1)'(1);
            end
            // an illegal accept outranks a same-cycle clear
            if (accept && !enc_legal) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_issue.sv
// tb/tb_instr_encoder_issue.sv - self-checking bench for instr_encoder_issue
module tb_instr_encoder_issue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_err = 1'b0;
    logic [4:0]  op_sel = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;
    logic        in_ready;
    logic        out_valid;
    logic        err;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic [15:0] word_count;

    int n_vec = 0;
    int n_fail = 0;

    instr_encoder_issue #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err(err), .clr_err(clr_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level encoding table: {legal, word}
    function automatic logic [32:0] model_enc(input int op, input logic [4:0] s, input logic [4:0] t,
                                              input logic [4:0] d, input logic [15:0] im,
                                              input logic [25:0] tg);
        logic [5:0] rfun [3];
        logic [5:0] iop  [6];
        rfun = '{6'h20, 6'h22, 6'h2a};
        iop  = '{6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0e};
        if (op <= 2)       return {1'b1, 6'h00, s, t, d, 5'h00, rfun[op]};
        else if (op == 3)  return {1'b1, 6'h00, s, 15'h0, 6'h08};
        else if (op == 4)  return {1'b1, 6'h00, s, t, 10'h0, 6'h18};
        else if (op <= 6)  return {1'b1, 16'h0, d, 5'h00, (op == 5) ? 6'h10 : 6'h12};
        else if (op <= 12) return {1'b1, iop[op-7], s, t, im};
        else if (op <= 14) return {1'b1, (op == 13) ? 6'h02 : 6'h03, tg};
        else if (op <= 16) return {1'b1, 6'h11, 5'h10, t, s, d, 6'(op - 15)};
`ifdef DOUBLE_FMT_EN
        else if (op <= 18) return {1'b1, 6'h11, 5'h11, t, s, d, 6'(op - 17)};
`endif
        return 33'h0;
    endfunction

    logic [31:0] mq [$];
    logic [31:0] m_addr = '0;
    logic [15:0] m_cnt = '0;
    logic        m_err = 1'b0;
    logic [32:0] m_e;
    bit          m_pop;
    bit          m_acc;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_addr = '0;
            m_cnt  = '0;
            m_err  = 1'b0;
        end else begin
            m_pop = (mq.size() > 0) && out_ready;
            m_acc = in_valid && (mq.size() < DEPTH);
            m_e   = model_enc(int'(op_sel), rs, rt, rd, imm, target);
            if (m_pop) begin
                void'(mq.pop_front());
                m_addr = m_addr + 32'd4;
                m_cnt  = m_cnt + 16'd1;
            end
            if (m_acc && m_e[32]) mq.push_back(m_e[31:0]);
            if (m_acc && !m_e[32]) m_err = 1'b1;
            else if (clr_err) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", {31'h0, out_valid}, {31'h0, mq.size() != 0});
        chk("in_ready", {31'h0, in_ready}, {31'h0, mq.size() < DEPTH});
        chk("out_instr", out_instr, (mq.size() != 0) ? mq[0] : 32'h0);
        chk("out_addr", out_addr, m_addr);
        chk("word_count", {16'h0, word_count}, {16'h0, m_cnt});
        chk("err", {31'h0, err}, {31'h0, m_err});
    end

    task automatic drive(input int op, input int s, input int t, input int d, input int im, input int tg);
        op_sel = 5'(op); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(im); target = 26'(tg);
        in_valid = 1'b1;
    endtask

    task automatic enc_case(input string name, input int op, input int s, input int t, input int d,
                            input int im, input int tg, input logic [31:0] exp);
        out_ready = 1'b0;
        drive(op, s, t, d, im, tg);
        @(posedge clk); #1 in_valid = 1'b0;
        chk({name, "_valid"}, {31'h0, out_valid}, 32'h1);
        chk(name, out_instr, exp);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        int b;
        #2 reset = 1'b1;
        #1;
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_word_count", {16'h0, word_count}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;

        out_ready = 1'b0;
        drive(0, 1, 2, 3, 0, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("add_addr", out_addr, 32'h0);
        chk("add_valid", {31'h0, out_valid}, 32'h1);
        chk("add_word", out_instr, 32'h00221820);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;

        enc_case("addi", 11, 0, 8, 0, 16'h0005, 0, 32'h20080005);
        enc_case("j", 13, 0, 0, 0, 0, 26'h0000010, 32'h08000010);
        enc_case("jr", 3, 31, 0, 0, 0, 0, 32'h03E00008);
        enc_case("add_s", 15, 4, 6, 2, 0, 0, 32'h46062080);
        enc_case("sltmix", 2, 7, 9, 11, 0, 0, 32'h00E9582A);
`ifdef DOUBLE_FMT_EN
        enc_case("add_d", 17, 4, 6, 2, 0, 0, 32'h46262080);
`else
        drive(17, 4, 6, 2, 0, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("op17_err", {31'h0, err}, 32'h1);
        chk("op17_noword", {31'h0, out_valid}, 32'h0);
        clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
`endif

        reset = 1'b1; #1 reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(11, 0, 8, 0, i, 0);
            @(posedge clk); #1;
        end
        chk("bp_full", {31'h0, in_ready}, 32'h0);
        drive(11, 0, 8, 0, 4, 0);
        @(posedge clk); #1;
        chk("bp_held", {31'h0, in_ready}, 32'h0);
        chk("bp_head", out_instr, 32'h20080000);
        out_ready = 1'b1;
        b = 0;
        while (!in_ready && b < 10) begin @(posedge clk); #1; b++; end
        chk("bp_room", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1 in_valid = 1'b0;
        b = 0;
        while (out_valid && b < 20) begin @(posedge clk); #1; b++; end
        chk("bp_drained", {31'h0, out_valid}, 32'h0);
        chk("bp_count", {16'h0, word_count}, 32'h5);
        chk("bp_addr", out_addr, 32'h14);
        out_ready = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(0, i, i + 1, i + 2, 0, 0);
            @(posedge clk); #1;
            chk("stream_ready", {31'h0, in_ready}, 32'h1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("stream_empty", {31'h0, out_valid}, 32'h0);
        chk("stream_count", {16'h0, word_count}, 32'hF);
        out_ready = 1'b0;

        drive(25, 1, 1, 1, 0, 0);
        @(posedge clk); #1 in_valid = 1'b0;
        chk("ill_err", {31'h0, err}, 32'h1);
        chk("ill_nofifo", {31'h0, out_valid}, 32'h0);
        chk("ill_ready", {31'h0, in_ready}, 32'h1);
        clr_err = 1'b1;
        @(posedge clk); #1 clr_err = 1'b0;
        chk("clr_err", {31'h0, err}, 32'h0);
        clr_err = 1'b1;
        drive(25, 0, 0, 0, 0, 0);
        @(posedge clk); #1 clr_err = 1'b0; in_valid = 1'b0;
        chk("set_wins", {31'h0, err}, 32'h1);

        for (int i = 0; i < 3; i++) begin
            drive(7, i, i, 0, 16'h10 * i, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_ready", {31'h0, in_ready}, 32'h1);
        chk("mid_rst_addr", out_addr, 32'h0);
        chk("mid_rst_count", {16'h0, word_count}, 32'h0);
        chk("mid_rst_err", {31'h0, err}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        enc_case("post_rst", 12, 3, 4, 0, 16'hBEEF, 0, 32'h3864BEEF);
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
